// File: rtl/sram_like_arbiter_if.sv
// One SRAM-like req/addr_ok/data_ok port; master drives the request, slave answers it.
interface sram_like_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          req;
  logic          wr;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          addr_ok;
  logic          data_ok;
  logic [DW-1:0] rdata;

  modport master (output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_arbiter.sv
// Shares one downstream SRAM-like port between the CPU inst and data ports,
// tagging each accepted address with its owner so in-order returns are routed back.
module sram_like_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                clk,
  input  logic                rst,
  sram_like_arbiter_if.slave  inst,
  sram_like_arbiter_if.slave  data,
  sram_like_arbiter_if.master m,
  output logic                err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [DEPTH-1:0] r_owner;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_streak;
  logic             r_err;

  logic w_full;
  logic w_starved;
  logic w_gnt_inst;
  logic w_gnt_data;
  logic w_push;
  logic w_pop;
  logic w_head;
  logic w_dok_empty;
  logic w_unused;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_starved   = (r_streak == SW'(STARVE_LIMIT));
  assign w_push      = (w_gnt_inst | w_gnt_data) & m.addr_ok;
  assign w_pop       = ~rst & m.data_ok & (r_count != '0);
  assign w_dok_empty = m.data_ok & (r_count == '0);
  assign w_head      = r_owner[r_rd_ptr];
  assign err         = r_err;

  // The inst port is read-only word fetch; its write-side fields carry nothing.
  assign w_unused = ^{inst.wr, inst.size, inst.wdata};

  // Data normally wins; inst is forced ahead once it has lost STARVE_LIMIT times in a row.
  always_comb begin
    w_gnt_inst = 1'b0;
    w_gnt_data = 1'b0;
    if (!rst && !w_full) begin
      if (data.req && !(inst.req && w_starved)) begin
        w_gnt_data = 1'b1;
      end else if (inst.req) begin
        w_gnt_inst = 1'b1;
      end
    end
  end

  // Downstream request mux and upstream handshake/return routing.
  always_comb begin
    m.req         = w_gnt_inst | w_gnt_data;
    m.wr          = w_gnt_data & data.wr;
    m.size        = w_gnt_data ? data.size  : 2'd2;
    m.addr        = w_gnt_data ? data.addr  : inst.addr;
    m.wdata       = w_gnt_data ? data.wdata : 32'd0;
    inst.addr_ok  = w_gnt_inst & m.addr_ok;
    data.addr_ok  = w_gnt_data & m.addr_ok;
    inst.data_ok  = w_pop & ~w_head;
    data.data_ok  = w_pop & w_head;
    inst.rdata    = m.rdata;
    data.rdata    = m.rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_streak <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_owner[r_wr_ptr] <= w_gnt_data;
        r_wr_ptr          <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      // A return with nothing outstanding (judged before this cycle's push) is fatal.
      if (w_dok_empty) begin
        r_err <= 1'b1;
      end
      if (!inst.req || (w_push && w_gnt_inst)) begin
        r_streak <= '0;
      end else if (w_push && w_gnt_data && !w_starved) begin
        r_streak <= r_streak + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized and directed bench for sram_like_arbiter against a queue-based owner model.
module tb_sram_like_arbiter;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned STARVE = 3;

  typedef enum int {G_NONE, G_INST, G_DATA} gnt_e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;

  sram_like_arbiter_if inst_if ();
  sram_like_arbiter_if data_if ();
  sram_like_arbiter_if m_if ();

  sram_like_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE)) dut (
    .clk  (clk),
    .rst  (rst),
    .inst (inst_if),
    .data (data_if),
    .m    (m_if),
    .err  (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: owners of outstanding transactions in issue order.
  bit   q_own[$];
  int   streak = 0;
  bit   m_err  = 1'b0;
  bit   last_acc_i, last_acc_d;

  // DUT values captured during the last tick, for directed checks.
  logic dut_mreq, dut_iaok, dut_daok, dut_idok, dut_ddok, dut_err;
  logic [31:0] dut_irdata, dut_drdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Compare all outputs against the model for the current inputs, then advance one clock.
  task automatic tick();
    gnt_e g;
    bit   pop, own;
    #1;
    g = G_NONE;
    if (!rst && q_own.size() < DEPTH) begin
      if (inst_if.req && data_if.req) g = (streak == STARVE) ? G_INST : G_DATA;
      else if (inst_if.req)           g = G_INST;
      else if (data_if.req)           g = G_DATA;
    end
    pop = !rst && m_if.data_ok && (q_own.size() > 0);
    own = pop ? q_own[0] : 1'b0;

    check("m_req", 32'(m_if.req), 32'(g != G_NONE));
    if (g == G_DATA) begin
      check("m_wr",    32'(m_if.wr),   32'(data_if.wr));
      check("m_size",  32'(m_if.size), 32'(data_if.size));
      check("m_addr",  m_if.addr,      data_if.addr);
      check("m_wdata", m_if.wdata,     data_if.wdata);
    end else if (g == G_INST) begin
      check("m_wr",    32'(m_if.wr),   32'd0);
      check("m_size",  32'(m_if.size), 32'd2);
      check("m_addr",  m_if.addr,      inst_if.addr);
      check("m_wdata", m_if.wdata,     32'd0);
    end
    check("inst_addr_ok", 32'(inst_if.addr_ok), 32'(g == G_INST && m_if.addr_ok));
    check("data_addr_ok", 32'(data_if.addr_ok), 32'(g == G_DATA && m_if.addr_ok));
    check("inst_data_ok", 32'(inst_if.data_ok), 32'(pop && !own));
    check("data_data_ok", 32'(data_if.data_ok), 32'(pop && own));
    check("inst_rdata",   inst_if.rdata, m_if.rdata);
    check("data_rdata",   data_if.rdata, m_if.rdata);
    check("err",          32'(err), 32'(m_err));

    dut_mreq   = m_if.req;
    dut_iaok   = inst_if.addr_ok;
    dut_daok   = data_if.addr_ok;
    dut_idok   = inst_if.data_ok;
    dut_ddok   = data_if.data_ok;
    dut_irdata = inst_if.rdata;
    dut_drdata = data_if.rdata;
    dut_err    = err;

    @(posedge clk);
    last_acc_i = (g == G_INST) && m_if.addr_ok;
    last_acc_d = (g == G_DATA) && m_if.addr_ok;
    if (rst) begin
      q_own.delete();
      streak = 0;
      m_err  = 1'b0;
    end else begin
      if (m_if.data_ok && q_own.size() == 0) m_err = 1'b1;
      if (pop) void'(q_own.pop_front());
      if (last_acc_i || last_acc_d) q_own.push_back(last_acc_d);
      if (!inst_if.req || last_acc_i) streak = 0;
      else if (last_acc_d && streak < STARVE) streak++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    inst_if.req     = 1'b0;
    data_if.req     = 1'b0;
    m_if.addr_ok    = 1'b0;
    m_if.data_ok    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  bit exp_d[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    idle();
    inst_if.wr    = 1'b1;          // junk on inst write fields must never leak out
    inst_if.size  = 2'd0;
    inst_if.wdata = 32'hDEAD_BEEF;
    inst_if.addr  = 32'h0;
    data_if.wr    = 1'b0;
    data_if.size  = 2'd2;
    data_if.addr  = 32'h0;
    data_if.wdata = 32'h0;
    m_if.rdata    = 32'h0;
    @(negedge clk);
    do_reset();

    // Inst-only stream with returns one cycle after each accept.
    inst_if.req  = 1'b1;
    m_if.addr_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      inst_if.addr = 32'h1000 + 32'(4 * k);
      m_if.data_ok = (k > 0);
      m_if.rdata   = 32'h100 + 32'(k);
      tick();
      check("istream_aok", 32'(dut_iaok), 32'd1);
      if (k > 0) check("istream_dok", 32'(dut_idok), 32'd1);
    end
    idle();
    m_if.data_ok = 1'b1;
    tick();
    m_if.data_ok = 1'b0;

    // Contention: data,data,data,inst repeating.
    do_reset();
    inst_if.req  = 1'b1;  inst_if.addr = 32'h1000;
    data_if.req  = 1'b1;  data_if.addr = 32'h2000; data_if.wr = 1'b0;
    m_if.addr_ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      m_if.data_ok = (q_own.size() > 0);
      m_if.rdata   = 32'(k);
      tick();
      check("gnt_seq_data", 32'(dut_daok), 32'(exp_d[k]));
      check("gnt_seq_inst", 32'(dut_iaok), 32'(!exp_d[k]));
    end

    // Ordering: inst, data read, inst; returns A, B, C.
    do_reset();
    m_if.addr_ok = 1'b1;
    inst_if.req = 1'b1; inst_if.addr = 32'h1000; tick();
    inst_if.req = 1'b0; data_if.req = 1'b1; data_if.wr = 1'b0; data_if.addr = 32'h2000; tick();
    data_if.req = 1'b0; inst_if.req = 1'b1; inst_if.addr = 32'h1004; tick();
    idle();
    m_if.data_ok = 1'b1;
    m_if.rdata = 32'hA; tick();
    check("ord0_inst", 32'(dut_idok), 32'd1);
    check("ord0_rd",   dut_irdata,    32'hA);
    m_if.rdata = 32'hB; tick();
    check("ord1_data", 32'(dut_ddok), 32'd1);
    check("ord1_inst", 32'(dut_idok), 32'd0);
    check("ord1_rd",   dut_drdata,    32'hB);
    m_if.rdata = 32'hC; tick();
    check("ord2_inst", 32'(dut_idok), 32'd1);
    check("ord2_rd",   dut_irdata,    32'hC);
    m_if.data_ok = 1'b0;

    // Full: four accepts with no return, then one return reopens the port.
    inst_if.req = 1'b1; m_if.addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    tick();
    check("full_mreq",  32'(dut_mreq), 32'd0);
    check("full_iaok",  32'(dut_iaok), 32'd0);
    m_if.data_ok = 1'b1; tick();
    check("full_pop_mreq", 32'(dut_mreq), 32'd0);
    m_if.data_ok = 1'b0; tick();
    check("reopen_mreq", 32'(dut_mreq), 32'd1);
    inst_if.req = 1'b0; m_if.data_ok = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    m_if.data_ok = 1'b0;

    // Simultaneous push/pop at count 2 keeps order: data, inst, data.
    data_if.req = 1'b1; data_if.wr = 1'b1; data_if.size = 2'd1; data_if.addr = 32'h3000;
    data_if.wdata = 32'h55AA; tick();
    data_if.req = 1'b0; inst_if.req = 1'b1; inst_if.addr = 32'h1008; tick();
    inst_if.req = 1'b0; data_if.req = 1'b1; data_if.wr = 1'b0; m_if.data_ok = 1'b1; tick();
    check("pp_pop_data", 32'(dut_ddok), 32'd1);
    check("pp_push",     32'(dut_daok), 32'd1);
    data_if.req = 1'b0; tick();
    check("pp_ret_inst", 32'(dut_idok), 32'd1);
    tick();
    check("pp_ret_data", 32'(dut_ddok), 32'd1);

    // Return with nothing outstanding sets sticky err.
    tick();
    check("empty_dok", 32'(dut_idok | dut_ddok), 32'd0);
    m_if.data_ok = 1'b0; tick();
    check("err_set", 32'(dut_err), 32'd1);
    tick();
    check("err_held", 32'(dut_err), 32'd1);

    // Reset with three outstanding, then a fresh inst request.
    inst_if.req = 1'b1; m_if.addr_ok = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    data_if.req = 1'b1; m_if.data_ok = 1'b1; rst = 1'b1; tick();
    check("rst_mreq", 32'(dut_mreq), 32'd0);
    check("rst_aok",  32'(dut_iaok | dut_daok), 32'd0);
    check("rst_dok",  32'(dut_idok | dut_ddok), 32'd0);
    rst = 1'b0; data_if.req = 1'b0; m_if.data_ok = 1'b0; tick();
    check("post_rst_err", 32'(dut_err),  32'd0);
    check("post_rst_aok", 32'(dut_iaok), 32'd1);
    inst_if.req = 1'b0; m_if.data_ok = 1'b1; m_if.rdata = 32'h77; tick();
    check("post_rst_dok", 32'(dut_idok), 32'd1);
    m_if.data_ok = 1'b0;

    // Randomized traffic; requesters hold until accepted.
    do_reset();
    last_acc_i = 1'b0;
    last_acc_d = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      if (!inst_if.req || last_acc_i) begin
        inst_if.req  = ($urandom_range(0, 3) != 0);
        inst_if.addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_if.req || last_acc_d) begin
        data_if.req   = ($urandom_range(0, 2) != 0);
        data_if.wr    = 1'($urandom_range(0, 1));
        data_if.size  = 2'($urandom_range(0, 2));
        data_if.addr  = $urandom;
        data_if.wdata = $urandom;
      end
      m_if.addr_ok = ($urandom_range(0, 3) != 0);
      m_if.data_ok = (q_own.size() > 0) && ($urandom_range(0, 1) == 1);
      m_if.rdata   = $urandom;
      rst          = (c % 300 == 299);
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
